// File: rtl/fetch_aligner_if.sv
// Fetch-word input, redirect and aligned-instruction output bundle for the fetch aligner.
// slave = aligner side, master = fetch unit / decoder side.
interface fetch_aligner_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        word_valid_i;
    logic [31:0] word_i;
    logic        word_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_c_o;
    logic        instr_ready_i;

    modport slave (
        input  redirect_i, redirect_pc_i, word_valid_i, word_i, instr_ready_i,
        output word_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_is_c_o
    );

    modport master (
        output redirect_i, redirect_pc_i, word_valid_i, word_i, instr_ready_i,
        input  word_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_is_c_o
    );
endinterface

// File: rtl/fetch_aligner.sv
// Splits 32-bit fetch words into whole RV32/RVC instructions with PCs; word in cycle N -> instr out N+1.
// Output register holds while stalled; word_ready_o is combinational and drops when the output cannot load.
module fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter bit          ENABLE_C  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    fetch_aligner_if.slave  bus
);

    // Without RVC every instruction is word aligned, so PC bit 1 is dropped too.
    localparam logic [31:0] PC_MASK   = ENABLE_C ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    localparam logic        BOOT_SKIP = ENABLE_C ? BOOT_ADDR[1] : 1'b0;

    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_is_c_q,  instr_is_c_d;
    logic [31:0] pc_q,          pc_d;
    logic [15:0] hw_q,          hw_d;
    logic        hw_valid_q,    hw_valid_d;
    logic        skip_lo_q,     skip_lo_d;

    logic        load;
    logic        consume;
    logic        emit;
    logic        emit_c;
    logic [31:0] emit_instr;

    assign load = !instr_valid_q || bus.instr_ready_i;

    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_is_c_d  = instr_is_c_q;
        pc_d          = pc_q;
        hw_d          = hw_q;
        hw_valid_d    = hw_valid_q;
        skip_lo_d     = skip_lo_q;
        consume       = 1'b0;
        emit          = 1'b0;
        emit_c        = 1'b0;
        emit_instr    = 32'h0;

        if (bus.redirect_i) begin
            instr_valid_d = 1'b0;
            hw_valid_d    = 1'b0;
            pc_d          = bus.redirect_pc_i & PC_MASK;
            skip_lo_d     = ENABLE_C ? bus.redirect_pc_i[1] : 1'b0;
        end else if (load) begin
            if (!ENABLE_C) begin
                if (bus.word_valid_i) begin
                    consume    = 1'b1;
                    emit       = 1'b1;
                    emit_instr = bus.word_i;
                end
            end else if (hw_valid_q && hw_q[1:0] != 2'b11) begin
                // Buffered compressed halfword drains without touching the word stream.
                emit       = 1'b1;
                emit_c     = 1'b1;
                emit_instr = {16'h0, hw_q};
                hw_valid_d = 1'b0;
            end else if (bus.word_valid_i) begin
                consume = 1'b1;
                if (hw_valid_q) begin
                    emit       = 1'b1;
                    emit_instr = {bus.word_i[15:0], hw_q};
                    hw_d       = bus.word_i[31:16];
                    hw_valid_d = 1'b1;
                end else if (skip_lo_q) begin
                    skip_lo_d = 1'b0;
                    if (bus.word_i[17:16] != 2'b11) begin
                        emit       = 1'b1;
                        emit_c     = 1'b1;
                        emit_instr = {16'h0, bus.word_i[31:16]};
                    end else begin
                        hw_d       = bus.word_i[31:16];
                        hw_valid_d = 1'b1;
                    end
                end else if (bus.word_i[1:0] == 2'b11) begin
                    emit       = 1'b1;
                    emit_instr = bus.word_i;
                end else begin
                    emit       = 1'b1;
                    emit_c     = 1'b1;
                    emit_instr = {16'h0, bus.word_i[15:0]};
                    hw_d       = bus.word_i[31:16];
                    hw_valid_d = 1'b1;
                end
            end

            instr_valid_d = emit;
            if (emit) begin
                instr_d      = emit_instr;
                instr_pc_d   = pc_q;
                instr_is_c_d = emit_c;
                pc_d         = pc_q + (emit_c ? 32'd2 : 32'd4);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_is_c_q  <= 1'b0;
            pc_q          <= BOOT_ADDR & PC_MASK;
            hw_q          <= 16'h0;
            hw_valid_q    <= 1'b0;
            skip_lo_q     <= BOOT_SKIP;
        end else begin
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_is_c_q  <= instr_is_c_d;
            pc_q          <= pc_d;
            hw_q          <= hw_d;
            hw_valid_q    <= hw_valid_d;
            skip_lo_q     <= skip_lo_d;
        end
    end

    assign bus.word_ready_o  = load && !bus.redirect_i && consume;
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = instr_pc_q;
    assign bus.instr_is_c_o  = instr_is_c_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed vector bench for fetch_aligner: per-cycle table plus a mid-straddle reset sequence.
module tb_fetch_aligner;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    fetch_aligner_if bus();

    fetch_aligner #(
        .BOOT_ADDR (32'h0000_0000),
        .ENABLE_C  (1'b1)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        wv;
        logic [31:0] w;
        logic        rdy;
        logic        e_wr;
        logic        e_v;
        logic [31:0] e_i;
        logic [31:0] e_pc;
        logic        e_c;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic rd, input logic [31:0] rpc, input logic wv, input logic [31:0] w,
                       input logic rdy, input logic e_wr, input logic e_v, input logic [31:0] e_i,
                       input logic [31:0] e_pc, input logic e_c);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.wv = wv; v.w = w; v.rdy = rdy;
        v.e_wr = e_wr; v.e_v = e_v; v.e_i = e_i; v.e_pc = e_pc; v.e_c = e_c;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] rpc, input logic wv,
                         input logic [31:0] w, input logic rdy);
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.word_valid_i  = wv;
        bus.word_i        = w;
        bus.instr_ready_i = rdy;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        //   rd   rpc           wv   word          rdy  e_wr e_v  e_instr       e_pc          e_c
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_0000, 1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h0010_0093, 1'b1, 1'b1, 1'b1, 32'h0010_0093, 32'h0000_0004, 1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h4501_4505, 1'b1, 1'b1, 1'b1, 32'h0000_4505, 32'h0000_0008, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h0513_4505, 1'b1, 1'b0, 1'b1, 32'h0000_4501, 32'h0000_000A, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h0513_4505, 1'b1, 1'b1, 1'b1, 32'h0000_4505, 32'h0000_000C, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h4581_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0513, 32'h0000_000E, 1'b0);
        add(1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_4581, 32'h0000_0012, 1'b1);
        add(1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b1, 32'h0000_0102, 1'b1, 32'h4585_1234, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h4585_1234, 1'b1, 1'b1, 1'b1, 32'h0000_4585, 32'h0000_0102, 1'b1);
        add(1'b1, 32'h0000_0202, 1'b1, 32'h0093_1111, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h0093_1111, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b1, 32'hABCD_0413, 1'b1, 1'b1, 1'b1, 32'h0413_0093, 32'h0000_0202, 1'b0);
        add(1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_ABCD, 32'h0000_0206, 1'b1);
        // Stall: output frozen, nothing consumed
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 32'h0000_0206, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 32'h0000_0206, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 32'h0000_0206, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_0208, 1'b0);
        // Redirect while stalled overrides the held output
        add(1'b0, 32'h0,        1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h0000_0208, 1'b0);
        add(1'b1, 32'h0000_0300, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h0010_0093, 1'b1, 1'b1, 1'b1, 32'h0010_0093, 32'h0000_0300, 1'b0);
        // PC wrap
        add(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h4505_0000, 1'b1, 1'b1, 1'b1, 32'h0000_4505, 32'hFFFF_FFFE, 1'b1);
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_0000, 1'b0);
        // Redirect discards a buffered compressed halfword
        add(1'b0, 32'h0,        1'b1, 32'h4501_4505, 1'b1, 1'b1, 1'b1, 32'h0000_4505, 32'h0000_0004, 1'b1);
        add(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0);
        add(1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_0010, 1'b0);

        @(posedge clk_i);
        #1;
        chk("reset valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("reset instr", bus.instr_o, 32'h0);
        chk("reset pc",    bus.instr_pc_o, 32'h0);
        chk("reset is_c",  {31'h0, bus.instr_is_c_o}, 32'h0);

        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk_i);
            drive(vq[i].rd, vq[i].rpc, vq[i].wv, vq[i].w, vq[i].rdy);
            #1;
            chk($sformatf("row%0d word_ready", i), {31'h0, bus.word_ready_o}, {31'h0, vq[i].e_wr});
            @(posedge clk_i);
            #1;
            chk($sformatf("row%0d valid", i), {31'h0, bus.instr_valid_o}, {31'h0, vq[i].e_v});
            if (vq[i].e_v) begin
                chk($sformatf("row%0d instr", i), bus.instr_o, vq[i].e_i);
                chk($sformatf("row%0d pc", i), bus.instr_pc_o, vq[i].e_pc);
                chk($sformatf("row%0d is_c", i), {31'h0, bus.instr_is_c_o}, {31'h0, vq[i].e_c});
            end
        end

        // Reset while a straddling 32-bit half sits in the buffer
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h0513_4505, 1'b1);
        @(posedge clk_i);
        #1;
        chk("pre-reset instr", bus.instr_o, 32'h0000_4505);
        chk("pre-reset pc", bus.instr_pc_o, 32'h0000_0014);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async reset valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("async reset instr", bus.instr_o, 32'h0);
        chk("async reset pc", bus.instr_pc_o, 32'h0);
        chk("async reset is_c", {31'h0, bus.instr_is_c_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b1);
        #1;
        chk("post-reset word_ready", {31'h0, bus.word_ready_o}, 32'h1);
        @(posedge clk_i);
        #1;
        chk("post-reset valid", {31'h0, bus.instr_valid_o}, 32'h1);
        chk("post-reset instr", bus.instr_o, 32'h0000_0013);
        chk("post-reset pc", bus.instr_pc_o, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
